write_back: RTL and testbench

Final stage of the RISC-V datapath, directly downstream of `memory_access`. It holds the instruction's control fields for one cycle, which aligns them with the registered `read_data` from `memory_access`. It then selects the ALU result or the sign/zero-extended load data, and commits the result to the 32×32 register file it owns. It also serves combinational register reads, with write-through bypass, to the decode stage and counts retired instructions.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/reg_file.sv | 33 +++
 rtl/write_back.sv | 93 +++++++++
 tb/tb_write_back.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath width, load funct3 codes and write-back control struct
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] funct3;
  } wb_ctrl_t;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register storage with one write port and two bypassed combinational read ports
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A value being committed this cycle is forwarded so decode sees it one cycle early.
  assign rdata1_o = (raddr1_i == 5'd0) ? '0 :
                    (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 :
                    (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - stage register, load extension, register commit and retired-instruction counter
module write_back #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [XLEN-1:0] ALU_result,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            mem_to_reg,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] read_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     instret
);
  import riscv_pkg::*;

  wb_ctrl_t        ctrl_q, ctrl_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [31:0]     instret_q, instret_d;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] result;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = valid_in & ~flush;
    ctrl_d.rd         = rd;
    ctrl_d.reg_write  = reg_write;
    ctrl_d.mem_to_reg = mem_to_reg;
    ctrl_d.funct3     = funct3;
    alu_d             = ALU_result;
    instret_d         = ctrl_q.valid ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      alu_q     <= '0;
      instret_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      instret_q <= instret_d;
    end
  end

  // read_data arrives registered, so it lines up with the staged fields, not the inputs.
  assign load_byte = read_data[{alu_q[1:0], 3'b000} +: 8];
  assign load_half = read_data[{alu_q[1], 4'b0000} +: 16];

  always_comb begin
    result = read_data;
    if (!ctrl_q.mem_to_reg) begin
      result = alu_q;
    end else begin
      case (ctrl_q.funct3)
        F3_LB:   result = {{(XLEN-8){load_byte[7]}}, load_byte};
        F3_LBU:  result = {{(XLEN-8){1'b0}}, load_byte};
        F3_LH:   result = {{(XLEN-16){load_half[15]}}, load_half};
        F3_LHU:  result = {{(XLEN-16){1'b0}}, load_half};
        default: result = read_data;
      endcase
    end
  end

  assign wb_en   = ctrl_q.valid & ctrl_q.reg_write & (ctrl_q.rd != 5'd0);
  assign wb_rd   = ctrl_q.rd;
  assign wb_data = result;
  assign instret = instret_q;

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_en),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - directed and random checks of write_back against a behavioural model
`timescale 1ns/100ps
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, flush, reg_write, mem_to_reg;
  logic [31:0] ALU_result, read_data;
  logic [4:0]  rd, rs1_addr, rs2_addr;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, wb_data, instret;
  logic        wb_en;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  // model state: architectural registers, counter and the instruction sitting in the stage
  logic [31:0] m_regs [32];
  logic [31:0] m_instret;
  logic        m_valid, m_rw, m_m2r;
  logic [31:0] m_alu;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  logic [31:0] exp_tab [5];
  logic [2:0]  f3_tab  [5];
  logic [1:0]  lane_tab[5];

  write_back dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .flush(flush),
    .ALU_result(ALU_result), .rd(rd), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .funct3(funct3), .read_data(read_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] rdat);
    logic signed [31:0] t;
    int lane;
    int h;
    lane = int'(m_alu[1:0]);
    h    = (lane >= 2) ? 1 : 0;
    if (!m_m2r) return m_alu;
    case (m_f3)
      3'b000: begin t = rdat << (24 - 8 * lane); return t >>> 24; end
      3'b100: return (rdat >> (8 * lane)) & 32'h0000_00FF;
      3'b001: begin t = rdat << (16 - 16 * h); return t >>> 16; end
      3'b101: return (rdat >> (16 * h)) & 32'h0000_FFFF;
      default: return rdat;
    endcase
  endfunction

  function automatic logic ref_en();
    return m_valid && m_rw && (m_rd != 5'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ref_en() && (m_rd == a)) return ref_result(read_data);
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instret = 0; m_valid = 0; m_rw = 0; m_m2r = 0; m_alu = 0; m_rd = 0; m_f3 = 0;
  endtask

  // present one cycle of inputs (read_data belongs to the already staged instruction) and check outputs
  task automatic setin(input logic v, input logic fl, input logic [31:0] alu, input logic [4:0] rdi,
                       input logic rw, input logic m2r, input logic [2:0] f3,
                       input logic [31:0] rdat, input logic [4:0] a1, input logic [4:0] a2);
    valid_in = v; flush = fl; ALU_result = alu; rd = rdi; reg_write = rw;
    mem_to_reg = m2r; funct3 = f3; read_data = rdat; rs1_addr = a1; rs2_addr = a2;
    #1;
    chk("wb_en", {31'd0, wb_en}, {31'd0, ref_en()});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
    chk("wb_data", wb_data, ref_result(read_data));
    chk("rs1_data", rs1_data, ref_read(a1));
    chk("rs2_data", rs2_data, ref_read(a2));
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_valid) m_instret = m_instret + 32'd1;
    if (ref_en()) m_regs[m_rd] = ref_result(read_data);
    m_valid = valid_in & ~flush; m_alu = ALU_result; m_rd = rd;
    m_rw = reg_write; m_m2r = mem_to_reg; m_f3 = funct3;
    #1;
    chk("instret", instret, m_instret);
  endtask

  task automatic bubble(input logic [31:0] rdat, input logic [4:0] a1);
    setin(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, rdat, a1, 5'd0);
  endtask

  initial begin
    exp_tab[0] = 32'hFFFF_FF80; f3_tab[0] = 3'b000; lane_tab[0] = 2'd3;
    exp_tab[1] = 32'h0000_0080; f3_tab[1] = 3'b100; lane_tab[1] = 2'd3;
    exp_tab[2] = 32'hFFFF_80FF; f3_tab[2] = 3'b001; lane_tab[2] = 2'd2;
    exp_tab[3] = 32'h0000_7F01; f3_tab[3] = 3'b101; lane_tab[3] = 2'd0;
    exp_tab[4] = 32'h80FF_7F01; f3_tab[4] = 3'b010; lane_tab[4] = 2'd1;

    model_reset();
    rst_n = 1'b0; valid_in = 0; flush = 0; ALU_result = 0; rd = 0; reg_write = 0;
    mem_to_reg = 0; funct3 = 0; read_data = 0; rs1_addr = 0; rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_instret", instret, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i + 16);
      #0.2;
      chk("rst_rs1", rs1_data, 32'd0);
      chk("rst_rs2", rs2_data, 32'd0);
    end

    // ALU write, bypass then storage read
    setin(1, 0, 32'h1234_5678, 5'd5, 1, 0, 3'b010, 32'd0, 5'd0, 5'd0); tick();
    bubble(32'd0, 5'd5);
    chk("alu_bypass", rs1_data, 32'h1234_5678);
    chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
    tick();
    bubble(32'd0, 5'd5);
    chk("alu_stored", rs1_data, 32'h1234_5678);
    chk("alu_instret", instret, 32'd1);
    tick();

    // load extension, back-to-back; each load's data arrives with the next instruction
    for (int i = 0; i <= 5; i++) begin
      if (i < 5)
        setin(1, 0, {28'h0000_100, 2'b00, lane_tab[i]}, 5'(10 + i), 1, 1, f3_tab[i],
              32'h80FF_7F01, 5'(9 + i), 5'd0);
      else
        bubble(32'h80FF_7F01, 5'd14);
      if (i > 0) chk($sformatf("load_%0d", i - 1), wb_data, exp_tab[i-1]);
      tick();
    end

    // x0 destination and store
    setin(1, 0, 32'hDEAD_BEEF, 5'd0, 1, 0, 3'b010, 32'd0, 5'd0, 5'd0); tick();
    setin(1, 0, 32'hCAFE_0001, 5'd6, 0, 0, 3'b010, 32'd0, 5'd0, 5'd0);
    chk("x0_wb_en", {31'd0, wb_en}, 32'd0);
    chk("x0_read", rs1_data, 32'd0);
    tick();
    bubble(32'd0, 5'd6);
    chk("store_no_wr", {31'd0, wb_en}, 32'd0);
    tick();

    // flush: staged instruction commits, captured one is killed
    setin(1, 0, 32'h0000_0055, 5'd12, 1, 0, 3'b010, 32'd0, 5'd0, 5'd0); tick();
    setin(1, 1, 32'h0000_0066, 5'd13, 1, 0, 3'b010, 32'd0, 5'd12, 5'd0);
    chk("flush_prev_commit", {31'd0, wb_en}, 32'd1);
    tick();
    bubble(32'd0, 5'd13);
    chk("flush_killed", {31'd0, wb_en}, 32'd0);
    tick();

    // counter wrap
    setin(1, 0, 32'h0000_0077, 5'd14, 1, 0, 3'b010, 32'd0, 5'd0, 5'd0); tick();
    force dut.instret_q = 32'hFFFF_FFFF;
    #0.5 release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    bubble(32'd0, 5'd0);
    tick();
    chk("instret_wrap", instret, 32'd0);

    // async reset while an instruction is staged
    setin(1, 0, 32'h0000_AAAA, 5'd9, 1, 0, 3'b010, 32'd0, 5'd9, 5'd0); tick();
    bubble(32'd0, 5'd9);
    chk("pre_rst_wb_en", {31'd0, wb_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_wb_en", {31'd0, wb_en}, 32'd0);
    chk("async_instret", instret, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    bubble(32'd0, 5'd9);
    chk("async_no_write", rs1_data, 32'd0);
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      setin(1'($urandom), ($urandom_range(0, 7) == 0), $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 3'($urandom), $urandom,
            5'($urandom), ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
